sram_ctrl: RTL and testbench

//  Parametrised single-port SRAM with valid/ready request and response channels. Replaces the
//  sel/ack pulse scheme with a pipelined interface: one request per cycle, configurable read

---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_ctrl_rsp_fifo.sv | 57 +++++
 rtl/sram_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared helpers and response metadata type for the pipelined SRAM controller.
package sram_pkg;

  typedef struct packed {
    logic we;
    logic err;
  } rsp_meta_t;

  localparam int RSP_META_W = $bits(rsp_meta_t);

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int be_w(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic int word_idx_w(input int addr_w, input int data_w, input int byte_w);
    return addr_w - clog2(data_w / byte_w);
  endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Fall-through response FIFO: an entry pushed into an empty FIFO is visible the same cycle.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  // a push that is popped in the same cycle from an empty FIFO bypasses storage
  assign wr_en   = push_i & ~(empty & pop_i);
  assign rd_en   = pop_i & ~empty;
  assign valid_o = ~empty | push_i;
  assign data_o  = empty ? push_data_i : buf_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM with valid/ready request/response channels, RD_LAT read pipeline and
// credit-gated skid FIFO. Optional per-lane even parity when SRAM_PARITY_EN is defined.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = be_w(DATA_WIDTH, BYTE_WIDTH),
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_BYTES-1:0]  req_be,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_we,
  output logic                  rsp_err
);

  localparam int OFF_W = clog2(NUM_BYTES);
  localparam int IDX_W = clog2(DEPTH);
  localparam int CRD_W = clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    rsp_meta_t             meta;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef SRAM_PARITY_EN
  logic [NUM_BYTES-1:0]  par_q [DEPTH];
`endif

  logic [ADDR_WIDTH-1:0] widx;
  logic [IDX_W-1:0]      idx;
  logic                  in_range, accept, pop;
  logic [CRD_W-1:0]      credits_q, credits_d;
  logic                  pipe_vld_q [RD_LAT];
  rsp_t                  pipe_rsp_q [RD_LAT];
  rsp_t                  rd_rsp, fifo_data;
  logic                  fifo_valid;
  logic [CRD_W-1:0]      fifo_cnt;

  assign widx      = req_addr >> OFF_W;
  assign idx       = widx[IDX_W-1:0];
  assign in_range  = ((widx >> IDX_W) == '0);
  assign req_ready = (credits_q < CRD_W'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign pop       = fifo_valid & rsp_ready;

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (req_be[b]) begin
          mem_q[idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= req_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SRAM_PARITY_EN
          par_q[idx][b] <= ^req_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
`endif
        end
      end
    end
  end

  // single port: a request is either a read or a write, so reading here never races a write
  always_comb begin
    rd_rsp          = '0;
    rd_rsp.meta.we  = req_we;
    rd_rsp.meta.err = ~in_range;
    if (in_range && !req_we) begin
      rd_rsp.rdata = mem_q[idx];
`ifdef SRAM_PARITY_EN
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (par_q[idx][b] != ^mem_q[idx][b*BYTE_WIDTH +: BYTE_WIDTH]) rd_rsp.meta.err = 1'b1;
      end
`endif
    end
  end

  // idle stages carry zeros so the fall-through output reads 0 when nothing is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_rsp_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_rsp_q[0] <= accept ? rd_rsp : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_rsp_q[i] <= pipe_rsp_q[i-1];
      end
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop)      credits_d = credits_q + 1'b1;
    else if (!accept && pop) credits_d = credits_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credits_q <= '0;
    else        credits_q <= credits_d;
  end

  sram_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pipe_vld_q[RD_LAT-1]),
    .push_data_i (pipe_rsp_q[RD_LAT-1]),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data),
    .count_o     (fifo_cnt)
  );

  assert property (@(posedge clk) disable iff (!rst_n) fifo_cnt <= credits_q);

  assign rsp_valid = fifo_valid;
  assign rsp_rdata = fifo_data.rdata;
  assign rsp_we    = fifo_data.meta.we;
  assign rsp_err   = fifo_data.meta.err;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: stimulus pushes expected responses, a monitor pops/compares.
module tb_sram_ctrl;

  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int DEPTH     = 1024;
  localparam int RD_LAT    = 1;
  localparam int RSP_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [3:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_we, rsp_err;
  logic [DW-1:0] rsp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        we;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   rsp_cyc[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_acc = 0;
  int   bad = 0;

  sram_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BYTE_WIDTH (8),
    .DEPTH      (DEPTH),
    .RD_LAT     (RD_LAT),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_we    (rsp_we),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual rdata 0x%08h required no response", rsp_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_we", rsp_we, mon_e.we);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: actual no accept required accept at addr 0x%08h", addr);
        break;
      end
    end
    if (req_ready) begin
      exp_q.push_back({er, we, ee});
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_we", rsp_we, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // byte-enable merge, write-then-read back to back
    issue(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b1, 4'b0010, 32'h10, 32'h0000AA00, 32'h0, 1'b0);
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    issue(1'b1, 4'b0000, 32'h10, 32'h12345678, 32'h0, 1'b0);
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    issue(1'b1, 4'b1111, 32'h0, 32'h11111111, 32'h0, 1'b0);
    wait_drain();

    // back-to-back reads: one response per cycle
    for (int i = 0; i < 8; i++)
      issue(1'b1, 4'b1111, 32'h100 + 32'(4*i), 32'hA5A50000 + 32'(i*32'h1111), 32'h0, 1'b0);
    wait_drain();
    rsp_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 4'b0000, 32'h100 + 32'(4*i), 32'h0, 32'hA5A50000 + 32'(i*32'h1111), 1'b0);
      if (i == 0) first_acc = acc_cyc;
    end
    wait_drain();
    chk("b2b_count", rsp_cyc.size(), 8);
    if (rsp_cyc.size() == 8) begin
      chk("b2b_first_latency", rsp_cyc[0] - first_acc, RD_LAT);
      for (int i = 1; i < 8; i++) chk("b2b_spacing", rsp_cyc[i] - rsp_cyc[i-1], 1);
    end

    // backpressure: credits exhaust after RSP_DEPTH accepts
    rsp_ready = 1'b0;
    for (int i = 0; i < RSP_DEPTH; i++)
      issue(1'b0, 4'b0000, 32'h100 + 32'(4*i), 32'h0, 32'hA5A50000 + 32'(i*32'h1111), 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h110;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready || !rsp_valid || rsp_rdata !== 32'hA5A50000) bad++;
    end
    chk("stall_ready_low_held_rsp", bad, 0);
    chk("stall_head_rdata", rsp_rdata, 32'hA5A50000);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 4'b0000, 32'h110, 32'h0, 32'hA5A54444, 1'b0);
    issue(1'b0, 4'b0000, 32'h114, 32'h0, 32'hA5A55555, 1'b0);
    wait_drain();

    // out-of-range access
    issue(1'b0, 4'b0000, 32'(4*DEPTH), 32'h0, 32'h0, 1'b1);
    issue(1'b1, 4'b1111, 32'(4*DEPTH), 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(1'b0, 4'b0000, 32'h0, 32'h0, 32'h11111111, 1'b0);
    wait_drain();

    // reset with responses outstanding; committed writes persist
    rsp_ready = 1'b0;
    issue(1'b0, 4'b0000, 32'h100, 32'h0, 32'hA5A50000, 1'b0);
    issue(1'b0, 4'b0000, 32'h104, 32'h0, 32'hA5A51111, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midreset_ready", req_ready, 1'b1);
    chk("midreset_no_rsp", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    wait_drain();

`ifdef SRAM_PARITY_EN
    issue(1'b1, 4'b1111, 32'h20, 32'h01020304, 32'h0, 1'b0);
    wait_drain();
    force dut.par_q[8][2] = 1'b0;
    issue(1'b0, 4'b0000, 32'h20, 32'h0, 32'h01020304, 1'b1);
    wait_drain();
    release dut.par_q[8][2];
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
